dpram_line_mover: RTL and testbench
===================================

// Module: dpram_line_mover
// PURPOSE
//  Requester for one port of the dual-port word RAM. Accepts line-sized read/write requests on a
//  valid/ready interface and sequences them as LINE_WORDS single-word RAM accesses.
//  Read data is collected into a full line and returned on a valid/ready response channel.
//  Sits between a cache/DMA client and port A or B of the RAM.
// PARAMETERS
//  AWIDTH     10  RAM word-address width
//  DWIDTH     32  RAM word width in bits; must be a multiple of 32
//  LINE_WORDS  8  words per line; must be a power of 2 and at least 2
// PORTS
//  clk        in   1                 clock; all state changes on the rising edge
//  reset      in   1                 synchronous, active-high
//  req_valid  in   1                 request present
//  req_ready  out  1                 request accepted when req_valid & req_ready
//  req_we     in   1                 1 = line write, 0 = line read
//  req_addr   in   AWIDTH            line word address; low log2(LINE_WORDS) bits are ignored (forced 0)
//  req_line   in   LINE_WORDS*DWIDTH write data; word k is [k*DWIDTH +: DWIDTH]
//  resp_valid out  1                 response present; held until resp_ready
//  resp_ready in   1                 response consumed when resp_valid & resp_ready
//  resp_we    out  1                 echoes req_we of the completed request
//  resp_line  out  LINE_WORDS*DWIDTH read line, same word order; 0 for write responses
//  mem_address out AWIDTH            RAM address
//  mem_wren   out  1                 RAM write enable
//  mem_byteen out  DWIDTH/8          RAM byte enables; bit (DWIDTH/8-1-j) enables byte j (bits j*8+:8)
//  mem_data   out  DWIDTH            RAM write data
//  mem_out    in   DWIDTH            RAM registered read data; valid 1 cycle after the address
// BEHAVIOUR
//  - Reset values: req_ready=0 while reset is high, state=IDLE.
//    mem_wren, mem_address, mem_data, resp_valid, resp_we and resp_line are 0. mem_byteen is all-ones.
//  - Reset while busy aborts at the next edge and returns to IDLE. Words already written stay written.
//    No response is generated for the aborted request.
//  - FSM states: IDLE, WRITE, READ, DRAIN, RESP.
//    req_ready=1 only in IDLE. A request is accepted at edge E0; this latches the address, we and line.
//  - WRITE: in cycles 1..N (N=LINE_WORDS) drive mem_wren=1, mem_address=base+k and mem_data=word k, k=0..N-1.
//    Then go to RESP. resp_valid is first high in cycle N+1.
//  - READ: in cycles 1..N drive mem_wren=0 and mem_address=base+k.
//    Capture mem_out into resp_line word k-1 in cycle k+1, covering cycles 2..N+1. Cycle N+1 is the DRAIN state.
//    resp_valid is first high in cycle N+2.
//  - RESP: hold resp_valid, resp_we and resp_line stable until resp_ready. Return to IDLE on that edge.
//    req_ready rises the following cycle, so there is no request/response overlap.
//  - Beat counter is log2(LINE_WORDS) bits. Address = {base[AWIDTH-1:L], cnt}, so there is no carry across the line.
//  - mem_wren is never asserted outside WRITE.
//  - The port never reads and writes in the same cycle.
//  - Collisions with the other RAM port are not detected; that is the client's responsibility.
// CONFIGURATION
//  DPRAM_MOVER_BYTEEN_EN defined:
//   - Adds input req_byteen [LINE_WORDS*DWIDTH/8] (word k, byte j = bit k*DWIDTH/8+j), latched at accept.
//   - mem_byteen drives the word's enables in the RAM's reversed order.
//   - A write word whose enables are all zero still spends its beat, with mem_wren=1 and byteen=0.
//  DPRAM_MOVER_BYTEEN_EN undefined: no such port; mem_byteen is all-ones on every beat.
// STRUCTURE
//  - Package dpram_mover_pkg holds the state enum (IDLE/WRITE/READ/DRAIN/RESP) and LOG2_LINE_WORDS = $clog2(LINE_WORDS).
//    It also holds the BYTEEN_ALL_ONES constant.
//  - No sub-module: the beat counter and FSM are inline.
// TESTING
//  Bench pairs this block with a behavioural 1-cycle registered RAM model.
//  1. Write line, addr=0x040, words 0x11111111*k: mem_wren high in cycles 1..8, addrs 0x040..0x047, resp_valid in cycle 9.
//  2. Read back 0x045 (low bits ignored): addrs 0x040..0x047, resp_valid in cycle 10, resp_line matches test 1.
//  3. resp_ready held low 5 cycles: resp_valid and resp_line stable, req_ready=0, new req_valid ignored until release.
//  4. Reset asserted in write cycle 4: RAM words 0..2 updated, words 3..7 unchanged; after reset req_ready=1 and resp_valid=0.
//  5. Top line, addr=(2^AWIDTH-8): addresses stay within 0x3F8..0x3FF and never wrap to 0.
//  6. DPRAM_MOVER_BYTEEN_EN: req_byteen word0 = 4'b0001 (byte 0 only) -> mem_byteen=4'b1000, only bits [7:0] of the RAM word change.

Source files
------------

// File: rtl/dpram_mover_pkg.sv
// Shared definitions for the dual-port RAM line mover: FSM state encoding,
// default geometry and the all-ones byte-enable constant.
package dpram_mover_pkg;

   localparam int DEF_AWIDTH      = 10;
   localparam int DEF_DWIDTH      = 32;
   localparam int DEF_LINE_WORDS  = 8;
   localparam int LOG2_LINE_WORDS = $clog2(DEF_LINE_WORDS);

   // Byte enables for a full-word write at the default word width.
   localparam logic [DEF_DWIDTH/8-1:0] BYTEEN_ALL_ONES = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/dpram_line_mover.sv
// Line requester for one port of the dual-port word RAM. A line request is
// accepted in IDLE and replayed as LINE_WORDS single-word accesses; read data
// is gathered into a line and returned on the response channel.
// Optional per-byte write enables: define DPRAM_MOVER_BYTEEN_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised by the source, holds its payload until that edge.
// req_ready is high only in IDLE (and never during reset); resp_valid is high
// only in RESP, so request and response never overlap.
module dpram_line_mover
   import dpram_mover_pkg::*;
#(
   parameter int AWIDTH     = DEF_AWIDTH,
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [AWIDTH-1:0]            req_addr,
   input  logic [LINE_WORDS*DWIDTH-1:0] req_line,
`ifdef DPRAM_MOVER_BYTEEN_EN
   input  logic [LINE_WORDS*DWIDTH/8-1:0] req_byteen,
`endif
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic                         resp_we,
   output logic [LINE_WORDS*DWIDTH-1:0] resp_line,
   output logic [AWIDTH-1:0]            mem_address,
   output logic                         mem_wren,
   output logic [DWIDTH/8-1:0]          mem_byteen,
   output logic [DWIDTH-1:0]            mem_data,
   input  logic [DWIDTH-1:0]            mem_out,
   output logic [2:0]                   dbg_state
);

   localparam int L  = $clog2(LINE_WORDS);
   localparam int BW = DWIDTH / 8;

   state_t                          state;
   state_t                          state_nxt;
   logic [L-1:0]                    cnt;
   logic [AWIDTH-L-1:0]             base_hi;
   logic                            we_q;
   logic [LINE_WORDS*DWIDTH-1:0]    line_q;
   logic                            cap_en;
   logic [L-1:0]                    cap_idx;
   logic                            accept;
   logic                            last_beat;
`ifdef DPRAM_MOVER_BYTEEN_EN
   logic [LINE_WORDS*BW-1:0]        be_q;
`endif

   // Line-offset bits of the request address are deliberately discarded.
   logic unused_addr_lo;
   assign unused_addr_lo = ^req_addr[L-1:0];

   assign accept    = req_valid & req_ready;
   assign last_beat = &cnt;
   assign dbg_state = state;
   assign resp_we   = we_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: one beat per cycle, DRAIN absorbs the RAM read latency.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_we ? WRITE : READ;
         WRITE:   if (last_beat) state_nxt = RESP;
         READ:    if (last_beat) state_nxt = DRAIN;
         DRAIN:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, beat counter and read-data capture one cycle behind the address.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         base_hi   <= '0;
         we_q      <= 1'b0;
         line_q    <= '0;
         resp_line <= '0;
         cap_en    <= 1'b0;
         cap_idx   <= '0;
`ifdef DPRAM_MOVER_BYTEEN_EN
         be_q      <= '0;
`endif
      end else begin
         cap_en  <= (state == READ);
         cap_idx <= cnt;
         if (accept) begin
            base_hi   <= req_addr[AWIDTH-1:L];
            we_q      <= req_we;
            line_q    <= req_line;
            cnt       <= '0;
            resp_line <= '0;
`ifdef DPRAM_MOVER_BYTEEN_EN
            be_q      <= req_byteen;
`endif
         end else begin
            if (state == WRITE || state == READ) cnt <= cnt + 1'b1;
            if (cap_en) resp_line[int'(cap_idx)*DWIDTH +: DWIDTH] <= mem_out;
         end
      end
   end

   // Outputs: RAM port driven only during beats; everything idle while reset is high.
   always_comb begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_wren    = 1'b0;
      mem_address = '0;
      mem_data    = '0;
      mem_byteen  = {BW{1'b1}};
      if (!reset) begin
         case (state)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
               mem_wren    = 1'b1;
               mem_address = {base_hi, cnt};
               mem_data    = line_q[int'(cnt)*DWIDTH +: DWIDTH];
`ifdef DPRAM_MOVER_BYTEEN_EN
               // RAM numbers its enables high-to-low relative to byte lanes.
               for (int j = 0; j < BW; j++)
                  mem_byteen[BW-1-j] = be_q[int'(cnt)*BW + j];
`endif
            end
            READ:  mem_address = {base_hi, cnt};
            RESP:  resp_valid = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_line_mover.sv
// Bench for dpram_line_mover with a 1-cycle registered RAM model and a shadow
// memory reference. Define DPRAM_MOVER_BYTEEN_EN to cover byte enables.
module tb_dpram_line_mover;
   import dpram_mover_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int N  = 8;
   localparam int LW = N * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_line = '0;
   logic [N*4-1:0] req_byteen = '1;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_we;
   logic [LW-1:0] resp_line;
   logic [AW-1:0] mem_address;
   logic          mem_wren;
   logic [3:0]    mem_byteen;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_out;
   logic [2:0]    dbg_state;

   logic [DW-1:0] ram [1024];
   logic [DW-1:0] ref_mem [1024];
   logic          ram_init = 1'b1;

   int n_chk  = 0;
   int n_pass = 0;

   // clock / reset
   always #5 clk = ~clk;

   dpram_line_mover #(.AWIDTH(AW), .DWIDTH(DW), .LINE_WORDS(N)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_line(req_line),
`ifdef DPRAM_MOVER_BYTEEN_EN
      .req_byteen(req_byteen),
`endif
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
      .resp_line(resp_line), .mem_address(mem_address), .mem_wren(mem_wren),
      .mem_byteen(mem_byteen), .mem_data(mem_data), .mem_out(mem_out),
      .dbg_state(dbg_state)
   );

   function automatic logic [DW-1:0] init_word(int i);
      return (32'h01010101 * i) ^ 32'hA5A5_0000;
   endfunction

   // registered-read RAM; bit (3-j) of byteen enables byte lane j
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      end else if (mem_wren) begin
         for (int j = 0; j < 4; j++)
            if (mem_byteen[3-j]) ram[mem_address][j*8 +: 8] <= mem_data[j*8 +: 8];
      end
      mem_out <= ram[mem_address];
   end

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [3:0] rev_be(logic [N*4-1:0] be, int k);
      logic [3:0] r;
      for (int j = 0; j < 4; j++) r[3-j] = be[k*4 + j];
      return r;
   endfunction

   // reference: apply a write line to the shadow memory byte by byte
   task automatic ref_write(input logic [AW-1:0] base, input logic [LW-1:0] line,
                            input logic [N*4-1:0] be, input int nwords);
      for (int k = 0; k < nwords; k++)
         for (int j = 0; j < 4; j++)
            if (be[k*4 + j]) ref_mem[base + k][j*8 +: 8] = line[k*DW + j*8 +: 8];
   endtask

   // driver: one complete request/response transaction with per-beat monitoring
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] line,
                         input logic [N*4-1:0] be, input int hold, input bit poke,
                         input int exp_lat, input logic [AW-1:0] exp_base);
      logic [LW-1:0] exp_line;
      logic [LW-1:0] first_line;
      logic [3:0]    exp_be;
      bit            addr_ok, wren_ok, data_ok, be_ok, busy_ok, hold_ok, ram_ok;
      int            cyc, wait_n;
      exp_line = '0;
      if (!we) for (int k = 0; k < N; k++) exp_line[k*DW +: DW] = ref_mem[exp_base + k];
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_line = line; req_byteen = be;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
      check("req_ready_idle", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      addr_ok = 1; wren_ok = 1; data_ok = 1; be_ok = 1; busy_ok = 1; hold_ok = 1; ram_ok = 1;
      for (int c = 1; c <= N; c++) begin
         if (mem_address !== exp_base + AW'(c - 1)) addr_ok = 0;
         if (mem_wren !== we) wren_ok = 0;
         if (we && mem_data !== line[(c-1)*DW +: DW]) data_ok = 0;
`ifdef DPRAM_MOVER_BYTEEN_EN
         exp_be = we ? rev_be(be, c - 1) : 4'hF;
`else
         exp_be = 4'hF;
`endif
         if (mem_byteen !== exp_be) be_ok = 0;
         if (req_ready !== 1'b0 || resp_valid !== 1'b0) busy_ok = 0;
         @(posedge clk); #1;
      end
      cyc = N + 1;
      while (!resp_valid && cyc < N + 10) begin
         if (mem_wren !== 1'b0) wren_ok = 0;
         @(posedge clk); #1; cyc++;
      end
      check("addr_seq", addr_ok, 1);
      check("wren_seq", wren_ok, 1);
      check("wdata_seq", data_ok, 1);
      check("byteen_seq", be_ok, 1);
      check("busy_no_ready", busy_ok, 1);
      check("resp_latency", cyc, exp_lat);
      check("resp_we", resp_we, we);
      check("resp_line", resp_line, exp_line);
      first_line = resp_line;
      for (int h = 0; h < hold; h++) begin
         if (poke) begin req_valid = 1'b1; req_we = 1'b0; req_addr = AW'($urandom_range(0, 1023)); end
         #1;
         if (resp_valid !== 1'b1 || resp_line !== first_line || req_ready !== 1'b0 || mem_wren !== 1'b0)
            hold_ok = 0;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (hold > 0) check("resp_hold_stable", hold_ok, 1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_released", resp_valid, 0);
      check("ready_after_resp", req_ready, 1);
      if (we) begin
         ref_write(exp_base, line, be, N);
         for (int k = 0; k < N; k++) if (ram[exp_base + k] !== ref_mem[exp_base + k]) ram_ok = 0;
         check("ram_contents", ram_ok, 1);
      end
   endtask

   // driver: write aborted by reset during beat 4
   task automatic do_abort(input logic [AW-1:0] addr, input logic [LW-1:0] line);
      logic [AW-1:0] base;
      bit            ram_ok;
      int            wait_n;
      base = {addr[AW-1:3], 3'b000};
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_line = line; req_byteen = '1;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c < 4; c++) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("abort_wren_low", mem_wren, 0);
      check("abort_ready_low", req_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_ready", req_ready, 1);
      check("abort_no_resp", resp_valid, 0);
      ref_write(base, line, '1, 3);
      ram_ok = 1;
      for (int k = 0; k < N; k++) if (ram[base + k] !== ref_mem[base + k]) ram_ok = 0;
      check("abort_ram_words", ram_ok, 1);
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
      check("abort_idle_no_resp", resp_valid, 0);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [LW-1:0] line;
      int            hold;
      bit            poke;
      int            exp_lat;
      logic [AW-1:0] exp_base;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [LW-1:0] l1, l2, l3, rl;
      logic          rwe;
      logic [AW-1:0] raddr;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      for (int k = 0; k < N; k++) begin
         l1[k*DW +: DW] = 32'h11111111 * k;
         l2[k*DW +: DW] = 32'hC0DE_0000 + 32'(k);
         l3[k*DW +: DW] = ~(32'h0F0F0F0F * (k + 1));
      end
      vecs[0] = '{1'b1, 10'h040, l1,  0, 1'b0, N + 1, 10'h040};
      vecs[1] = '{1'b0, 10'h045, '0,  0, 1'b0, N + 2, 10'h040};
      vecs[2] = '{1'b0, 10'h047, '0,  5, 1'b1, N + 2, 10'h040};
      vecs[3] = '{1'b1, 10'h3FB, l2,  1, 1'b0, N + 1, 10'h3F8};
      vecs[4] = '{1'b0, 10'h3FF, '0,  0, 1'b0, N + 2, 10'h3F8};
      vecs[5] = '{1'b1, 10'h008, l3,  2, 1'b0, N + 1, 10'h008};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_mem_wren", mem_wren, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_mem_byteen", mem_byteen, 4'hF);
      check("rst_resp_we", resp_we, 0);
      check("rst_resp_line", resp_line, 0);
      @(negedge clk);
      reset = 1'b0;
      ram_init = 1'b0;

      // table-driven directed vectors
      for (int v = 0; v < 6; v++)
         do_req(vecs[v].we, vecs[v].addr, vecs[v].line, '1, vecs[v].hold, vecs[v].poke,
                vecs[v].exp_lat, vecs[v].exp_base);

      // reset mid-write, then read the partially written line back
      do_abort(10'h100, l2);
      do_req(1'b0, 10'h100, '0, '1, 0, 1'b0, N + 2, 10'h100);

`ifdef DPRAM_MOVER_BYTEEN_EN
      // byte 0 only in word 0, full words elsewhere
      do_req(1'b1, 10'h080, l3, 32'hFFFF_FFF1, 0, 1'b0, N + 1, 10'h080);
      do_req(1'b0, 10'h080, '0, '1, 0, 1'b0, N + 2, 10'h080);
`endif

      // randomized traffic against the shadow memory
      for (int t = 0; t < 24; t++) begin
         rwe   = 1'($urandom_range(0, 1));
         raddr = AW'($urandom_range(0, 1023));
         for (int k = 0; k < N; k++) rl[k*DW +: DW] = $urandom;
         do_req(rwe, raddr, rl, '1, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                rwe ? N + 1 : N + 2, {raddr[AW-1:3], 3'b000});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
